instruction_fetch_queue: RTL and testbench

Front-end producer for the instruction decoder. It generates sequential fetch addresses and issues them to instruction memory under a credit limit. Returned instruction words are buffered in order in a small FIFO, and each word is presented to decode with its PC over a valid/ready handshake. A redirect from branch resolution or a flush empties the queue, discards all in-flight responses and restarts fetch at the new PC.

---
 rtl/instruction_fetch_queue.sv | 179 +++++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//
// Front-end producer for the instruction decoder. The block issues sequential
// word-aligned fetch addresses to instruction memory. A credit rule ensures
// that every response has a free queue slot. Returned words are buffered in
// order together with their PC and are handed to decode over valid/ready.
// A redirect empties the queue, marks every in-flight response for discard
// and restarts fetch at the new PC.
//
// Parameters:
//   XLEN         address / PC width
//   QUEUE_DEPTH  FIFO entries (power of two, >= 2)
//   RESET_PC     first fetch address after reset
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   imem_req_valid/addr/ready     fetch request channel to instruction memory
//   imem_resp_valid/data          in-order response channel (always accepted)
//   redirect_valid/pc             flush and restart fetch at redirect_pc
//   inst_valid/inst/inst_pc       head entry presented to decode
//   inst_ready                    decode consumes the head entry
// -----------------------------------------------------------------------------
module instruction_fetch_queue #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int unsigned     PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned     CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH = (CNT_W + 1)'(QUEUE_DEPTH);

    logic             active_q, active_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [31:0]      word_mem_q [QUEUE_DEPTH];
    logic [XLEN-1:0]  pc_mem_q   [QUEUE_DEPTH];

    logic             req_fire;
    logic             resp_fire;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  redirect_pc_aligned;

    // The low two bits of redirect_pc are forced to zero and never read.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign redirect_pc_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit: queued entries plus in-flight requests never exceed the depth,
    // so every non-dropped response is guaranteed a free slot.
    assign imem_req_valid = active_q && !redirect_valid &&
                            (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_fire      = imem_resp_valid && (outstanding_q != '0);

    assign inst_valid     = (count_q != '0) && !redirect_valid;
    assign pop            = inst_valid && inst_ready;

    // Head data is gated so that an empty queue (and reset) shows zeros
    // instead of stale storage contents.
    always_comb begin
        inst    = '0;
        inst_pc = '0;
        if (count_q != '0) begin
            inst    = word_mem_q[head_q];
            inst_pc = pc_mem_q[head_q];
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        active_d      = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        push          = 1'b0;

        if (redirect_valid) begin
            // Redirect wins over request, response and pop in this cycle.
            fetch_pc_d    = redirect_pc_aligned;
            resp_pc_d     = redirect_pc_aligned;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            outstanding_d = outstanding_q - CNT_W'(resp_fire);
            drop_d        = outstanding_q - CNT_W'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (resp_fire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    push = 1'b1;
                end
            end
            if (push) begin
                tail_d    = tail_q + PTR_W'(1);
                resp_pc_d = resp_pc_q + XLEN'(4);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q      <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            active_q      <= active_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; entry validity is fully
    // described by count_q, and the outputs are gated while it is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem_q[tail_q] <= imem_resp_data;
            pc_mem_q[tail_q]   <= resp_pc_q;
        end
    end

    resp_without_request: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(imem_resp_valid && (outstanding_q == '0))
    );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_queue
//
// Bench for instruction_fetch_queue. An in-order memory model with
// configurable latency answers requests. A queue-based reference model
// predicts the request credit, the fetch addresses, the decode stream and
// the discard of responses after a redirect. Scenario tasks add directed
// checks for latency, back-pressure, redirects, ready toggling and
// mid-stream reset.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    instruction_fetch_queue #(
        .XLEN(XLEN), .QUEUE_DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

    // memory model: requests in flight, in order
    req_t pend[$];
    int   last_due;
    int   lat_lo, lat_hi;
    int   cyc;

    // reference model
    ent_t        m_q[$];
    bit          m_active;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_resp_pc;
    int          m_drop;

    int tests_run;
    int tests_failed;

    // observations of the most recent cycle
    bit          o_req_valid, o_req_fire, o_inst_valid, o_pop;
    logic [31:0] o_req_addr, o_pop_pc, o_pop_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ a;
    endfunction

    task automatic model_clear();
        pend.delete();
        m_q.delete();
        last_due   = 0;
        m_active   = 1'b0;
        m_fetch_pc = RESET_PC;
        m_resp_pc  = RESET_PC;
        m_drop     = 0;
    endtask

    task automatic drive_idle();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b0;
    endtask

    // One clock cycle: called just after a falling edge, returns just after
    // the next falling edge.
    task automatic cycle(input bit rdy, input bit irdy, input bit redir,
                         input logic [31:0] rpc);
        bit          resp;
        bit          exp_req_valid, exp_inst_valid;
        logic [31:0] resp_data;
        int          due;
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        resp           = (pend.size() > 0) && (pend[0].due <= cyc);
        resp_data      = resp ? mem_word(pend[0].addr) : $urandom;
        imem_resp_valid = resp;
        imem_resp_data  = resp_data;
        #1;
        exp_req_valid  = m_active && !redir && ((m_q.size() + pend.size()) < DEPTH);
        exp_inst_valid = (m_q.size() > 0) && !redir;

        tests_run++;
        if (imem_req_valid !== exp_req_valid) begin
            tests_failed++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req_valid);
        end
        if (exp_req_valid) begin
            tests_run++;
            if (imem_req_addr !== m_fetch_pc) begin
                tests_failed++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch_pc);
            end
        end
        tests_run++;
        if (inst_valid !== exp_inst_valid) begin
            tests_failed++;
            $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_inst_valid);
        end
        if (exp_inst_valid) begin
            tests_run++;
            if (inst !== m_q[0].data || inst_pc !== m_q[0].pc) begin
                tests_failed++;
                $display("FAIL head cyc=%0d got=%h@%h exp=%h@%h", cyc, inst, inst_pc,
                         m_q[0].data, m_q[0].pc);
            end
        end

        o_req_valid  = imem_req_valid;
        o_req_addr   = imem_req_addr;
        o_req_fire   = imem_req_valid && rdy;
        o_inst_valid = inst_valid;
        o_pop        = inst_valid && irdy;
        o_pop_pc     = inst_pc;
        o_pop_data   = inst;

        @(posedge clk);
        if (redir) begin
            m_drop     = pend.size() - (resp ? 1 : 0);
            m_q.delete();
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
            m_resp_pc  = rpc & 32'hFFFF_FFFC;
        end else begin
            if (exp_req_valid && rdy) m_fetch_pc = m_fetch_pc + 32'd4;
            if (exp_inst_valid && irdy) void'(m_q.pop_front());
            if (resp) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    m_q.push_back(ent_t'{resp_data, m_resp_pc});
                    m_resp_pc = m_resp_pc + 32'd4;
                end
            end
        end
        if (resp) void'(pend.pop_front());
        if (o_req_fire) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back(req_t'{o_req_addr, due});
        end
        m_active = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    // Holds reset for two cycles, checks the reset outputs and releases it
    // at a falling edge; the caller's next cycle is cycle 0.
    task automatic apply_reset();
        drive_idle();
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        tests_run++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== RESET_PC ||
            inst !== 32'h0 || inst_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got rv=%b iv=%b addr=%h inst=%h pc=%h exp 0 0 %h 0 0",
                     imem_req_valid, inst_valid, imem_req_addr, inst, inst_pc, RESET_PC);
        end
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic test_reset();
        int first = -1;
        int delivered = 0;
        logic [31:0] first_pc = 32'hDEAD_BEEF;
        lat_lo = 1; lat_hi = 1;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (o_pop) begin
                if (first < 0) begin first = i; first_pc = o_pop_pc; end
                delivered++;
            end
        end
        tests_run++;
        if (first !== 3 || first_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL first_inst got cycle=%0d pc=%h exp cycle=3 pc=0", first, first_pc);
        end
        tests_run++;
        if (delivered !== 17) begin
            tests_failed++;
            $display("FAIL throughput got=%0d exp=17", delivered);
        end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        logic [31:0] addr = '0;
        lat_lo = 1; lat_hi = 1;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, '0);
            if (o_req_fire) fires++;
        end
        tests_run++;
        if (fires !== 4 || o_req_valid !== 1'b0 || o_inst_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_queue got fires=%0d rv=%b iv=%b exp 4 0 1", fires, o_req_valid, o_inst_valid);
        end
        cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (o_pop !== 1'b1 || o_pop_pc !== 32'h0 || o_pop_data !== mem_word(32'h0)) begin
            tests_failed++;
            $display("FAIL single_pop got pop=%b pc=%h exp pop=1 pc=0", o_pop, o_pop_pc);
        end
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0, '0);
            if (o_req_fire) begin fires++; addr = o_req_addr; end
        end
        tests_run++;
        if (fires !== 1 || addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL refill got fires=%0d addr=%h exp 1 00000010", fires, addr);
        end
    endtask

    task automatic test_redirect();
        int fires = 0;
        bit seen = 0;
        lat_lo = 3; lat_hi = 3;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (o_req_fire) fires++;
        end
        tests_run++;
        if (fires !== 3) begin
            tests_failed++;
            $display("FAIL pre_redirect_reqs got=%0d exp=3", fires);
        end
        cycle(1'b1, 1'b1, 1'b1, 32'h103);
        cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (o_req_fire !== 1'b1 || o_req_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL redirect_addr got fire=%b addr=%h exp 1 00000100", o_req_fire, o_req_addr);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (o_pop) begin
                seen = 1;
                tests_run++;
                if (o_pop_pc !== 32'h100 || o_pop_data !== mem_word(32'h100)) begin
                    tests_failed++;
                    $display("FAIL redirect_first got %h@%h exp %h@00000100", o_pop_data, o_pop_pc,
                             mem_word(32'h100));
                end
            end
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL redirect_first got no instruction within 20 cycles exp pc 00000100");
        end
    endtask

    task automatic test_redirect_with_resp();
        int first = -1;
        logic [31:0] pc = '0;
        apply_reset();
        lat_lo = 1; lat_hi = 1;
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        lat_lo = 2; lat_hi = 2;
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        tests_run++;
        if (o_inst_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_redirect_valid got=%b exp=1", o_inst_valid);
        end
        cycle(1'b1, 1'b1, 1'b1, 32'h2000);
        tests_run++;
        if (o_inst_valid !== 1'b0 || o_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_cycle got iv=%b rv=%b exp 0 0", o_inst_valid, o_req_valid);
        end
        for (int i = 7; i < 20 && first < 0; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (o_pop) begin first = i; pc = o_pop_pc; end
        end
        tests_run++;
        if (first !== 10 || pc !== 32'h2000) begin
            tests_failed++;
            $display("FAIL drop_one got cycle=%0d pc=%h exp cycle=10 pc=00002000", first, pc);
        end
    endtask

    task automatic test_toggle_ready();
        int delivered = 0;
        bit prev_stall = 0;
        logic [31:0] prev_addr = '0;
        lat_lo = 1; lat_hi = 1;
        apply_reset();
        for (int i = 0; i < 200 && delivered < 16; i++) begin
            cycle(i[0], 1'b1, 1'b0, '0);
            if (prev_stall) begin
                tests_run++;
                if (o_req_addr !== prev_addr) begin
                    tests_failed++;
                    $display("FAIL addr_hold cyc=%0d got=%h exp=%h", i, o_req_addr, prev_addr);
                end
            end
            prev_stall = o_req_valid && !i[0];
            prev_addr  = o_req_addr;
            if (o_pop) begin
                tests_run++;
                if (o_pop_pc !== 32'(delivered * 4)) begin
                    tests_failed++;
                    $display("FAIL toggle_seq got=%h exp=%h", o_pop_pc, 32'(delivered * 4));
                end
                delivered++;
            end
        end
        tests_run++;
        if (delivered !== 16) begin
            tests_failed++;
            $display("FAIL toggle_count got=%0d exp=16", delivered);
        end
    endtask

    task automatic test_random();
        int delivered = 0;
        bit redir;
        logic [31:0] rpc;
        lat_lo = 1; lat_hi = 4;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            redir = ($urandom_range(99, 0) < 3);
            rpc   = $urandom_range(1, 0) ? (32'hFFFF_FFF0 + $urandom_range(15, 0)) : $urandom;
            cycle($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70, redir, rpc);
            if (o_pop) delivered++;
        end
        tests_run++;
        if (delivered < 200) begin
            tests_failed++;
            $display("FAIL random_progress got=%0d exp>=200", delivered);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        lat_lo = 1; lat_hi = 1;
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        tests_run++;
        if (o_inst_valid !== 1'b1 || o_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL prereset_full got iv=%b rv=%b exp 1 0", o_inst_valid, o_req_valid);
        end
        drive_idle();
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL async_reset got iv=%b rv=%b addr=%h exp 0 0 %h", inst_valid,
                     imem_req_valid, imem_req_addr, RESET_PC);
        end
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 6 && !seen; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (o_req_fire) begin
                seen = 1;
                tests_run++;
                if (o_req_addr !== RESET_PC || i !== 1) begin
                    tests_failed++;
                    $display("FAIL restart got addr=%h cycle=%0d exp %h cycle 1", o_req_addr, i, RESET_PC);
                end
            end
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL restart got no request within 6 cycles exp addr %h", RESET_PC);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        lat_lo       = 1;
        lat_hi       = 1;
        drive_idle();
        reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_backpressure();
        test_redirect();
        test_redirect_with_resp();
        test_toggle_ready();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
